code_lock_fsm: RTL
==================

# code_lock_fsm

Parametrised combination-lock controller for board-level lab harnesses. It takes a code of `CODE_LEN` digits, each `WIDTH` bits, one digit per `ENTER` press, and opens on a correct sequence. It counts failed attempts, holds a timed lockout after `MAX_TRIES` consecutive failures, and lets the user re-program the code while the lock is open. Board inputs (`SW`, `KEY`) drive it through the top-level wrapper, and its outputs drive `LEDR`/`HEX` indicators.

## Interface
- `CODE_LEN`, default 4: digits per code (≥1).
- `WIDTH`, default 4: bits per digit.
- `MAX_TRIES`, default 3: failed attempts allowed before lockout (≥1).
- `LOCKOUT_CYCLES`, default 8: lockout duration in clk cycles (≥1).
- `DEFAULT_CODE`, default 16'h4321: reset code, `CODE_LEN*WIDTH` bits; digit i sits at `[i*WIDTH +: WIDTH]`, and digit 0 is entered first.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `ENTER`  in  1  active-high level. A 0→1 transition sampled at clk is one "accepted press".
- `DIGIT`  in  WIDTH  digit value, sampled in the accepted-press cycle.
- `PROGRAM`  in  1  level; in OPEN, an accepted press with `PROGRAM`=1 starts programming.
- `LOCK`  in  1  level; relocks from OPEN and aborts programming.
- `UNLOCKED`  out  1  high in OPEN and PROG.
- `FAIL`  out  1  one-cycle pulse after each completed wrong entry.
- `LOCKED_OUT`  out  1  high in LOCKOUT.
- `POS`  out  $clog2(CODE_LEN+1)  digits captured in the current entry or programming pass.
- `TRIES_LEFT`  out  $clog2(MAX_TRIES+1)  remaining attempts.

## Operation
- **Edge detect.** `enter_q` holds `ENTER` from the previous cycle. A press is accepted when `ENTER & ~enter_q`. A held key gives exactly one press. `enter_q` keeps tracking in every state.
- **States:** ENTRY, OPEN, PROG, LOCKOUT. All outputs are registered.
- **ENTRY.**
  - On a press, compare `DIGIT` with stored digit `POS`, OR any mismatch into a sticky `bad` flag, then `POS`++.
  - On the press where `POS`==`CODE_LEN`-1, decide using `bad`|this-digit-mismatch:
    - Match: go to OPEN, set `TRIES_LEFT`=`MAX_TRIES`.
    - Mismatch: pulse `FAIL`, decrement `TRIES_LEFT`. If the result is 0, go to LOCKOUT and load the counter with `LOCKOUT_CYCLES`-1. Otherwise stay in ENTRY.
  - In every case `POS`←0 and `bad`←0.
- **OPEN.**
  - `LOCK`=1: go to ENTRY, `POS`=0.
  - Press with `PROGRAM`=1 and `LOCK`=0: go to PROG, `POS`=0. That same press is not captured as a digit.
  - Press with `PROGRAM`=0: ignored.
- **PROG.**
  - Each press writes `DIGIT` into the shadow code at `POS`, then `POS`++.
  - On the `CODE_LEN`-th digit, copy the shadow into the stored code, go to ENTRY (locked), set `POS`=0 and `TRIES_LEFT`=`MAX_TRIES`.
  - `LOCK`=1 in PROG aborts: go to OPEN, stored code unchanged, `POS`=0.
- **LOCKOUT.**
  - Presses are ignored; the counter decrements each cycle.
  - In the cycle the counter is 0, go to ENTRY with `POS`=0 and `TRIES_LEFT`=`MAX_TRIES`.
- **Priority:** `RESET` > `LOCK` > press.
- **Reset values:** state ENTRY, stored code `DEFAULT_CODE`, shadow `DEFAULT_CODE`, `POS`=0, `bad`=0, `TRIES_LEFT`=`MAX_TRIES`, `UNLOCKED`=0, `FAIL`=0, `LOCKED_OUT`=0, counter 0, `enter_q`=1.
  - Because `enter_q` resets to 1, a key held through reset does not count as a press.
  - `RESET` mid-entry or mid-program discards all partial input and restores `DEFAULT_CODE`.

## Timing
- Latency is one cycle from an accepted press to the updated `POS`, `UNLOCKED`, `FAIL`, `LOCKED_OUT` and `TRIES_LEFT`.
- `FAIL` is high for exactly one cycle, including on the failure that enters LOCKOUT.
- `LOCKED_OUT` is high for exactly `LOCKOUT_CYCLES` cycles. `TRIES_LEFT` shows 0 throughout lockout and reads `MAX_TRIES` on the first cycle of ENTRY after it.
- `LOCK` acts in the cycle it is sampled high. `UNLOCKED` falls on the next cycle.
- `POS` never exceeds `CODE_LEN`-1 as a visible value; it wraps to 0 at completion.
- A press needs `ENTER` low for at least one sampled cycle between presses.

## Test plan
All scenarios use the defaults.
- **Correct code.** Presses 1,2,3,4 → `POS` reads 1,2,3 after each of the first three presses; after the 4th, `UNLOCKED`=1, `POS`=0, `TRIES_LEFT`=3, `FAIL` never asserted.
- **Single wrong entry.** Presses 1,2,9,4 → `FAIL` pulses for one cycle after the 4th press, `TRIES_LEFT`=2, `UNLOCKED`=0. Then 1,2,3,4 → `UNLOCKED`=1 and `TRIES_LEFT`=3.
- **Lockout.** Three wrong 4-digit entries → third entry gives a `FAIL` pulse, `LOCKED_OUT`=1 for 8 cycles, and presses during lockout leave `POS`=0. Afterwards `TRIES_LEFT`=3, and 1,2,3,4 unlocks.
- **Held key and reset.** `ENTER` held high for 10 cycles with `DIGIT`=1 → `POS`=1, one press only. `ENTER` held through `RESET` deassertion → `POS` stays 0 until `ENTER` goes low then high again.
- **Re-program.** Open the lock, press with `PROGRAM`=1, then enter 5,6,7,8 → `UNLOCKED`=0 after the 4th digit. 1,2,3,4 then gives `FAIL`; 5,6,7,8 gives `UNLOCKED`=1.
- **Abort and priority.** In PROG after 2 digits, assert `LOCK` → OPEN, `POS`=0, and 1,2,3,4 still opens after relock. In OPEN, `LOCK` and a `PROGRAM` press in the same cycle → ENTRY, not PROG.

Source files
------------

// File: rtl/code_lock_fsm.sv
// Combination-lock controller: digit-by-digit code entry, failed-attempt lockout and
// re-programming while open. Outputs are registered and update one cycle after a press.
module code_lock_fsm #(
  parameter int unsigned                 CODE_LEN       = 4,
  parameter int unsigned                 WIDTH          = 4,
  parameter int unsigned                 MAX_TRIES      = 3,
  parameter int unsigned                 LOCKOUT_CYCLES = 8,
  parameter logic [CODE_LEN*WIDTH-1:0]   DEFAULT_CODE   = 16'h4321
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               enter_i,
  input  logic [WIDTH-1:0]                   digit_i,
  input  logic                               program_i,
  input  logic                               lock_i,
  output logic                               unlocked_o,
  output logic                               fail_o,
  output logic                               locked_out_o,
  output logic [$clog2(CODE_LEN+1)-1:0]      pos_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left_o
);

  localparam int unsigned PW = $clog2(CODE_LEN+1);
  localparam int unsigned TW = $clog2(MAX_TRIES+1);
  localparam int unsigned CW = $clog2(LOCKOUT_CYCLES+1);

  localparam logic [PW-1:0] LAST_POS   = PW'(CODE_LEN-1);
  localparam logic [TW-1:0] FULL_TRIES = TW'(MAX_TRIES);
  localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCKOUT_CYCLES-1);

  typedef enum logic [1:0] {
    S_ENTRY,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_e;

  typedef logic [CODE_LEN-1:0][WIDTH-1:0] code_t;

  state_e        state_q, state_d;
  code_t         code_q, code_d;
  code_t         shadow_q, shadow_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bad_q, bad_d;
  logic          fail_q, fail_d;
  logic          unlocked_q, unlocked_d;
  logic          locked_out_q, locked_out_d;
  logic          enter_q;

  logic             press;
  logic             mismatch;
  logic [WIDTH-1:0] cur_digit;

  assign press = enter_i & ~enter_q;

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (pos_q == PW'(i)) begin
        cur_digit = code_q[i];
      end
    end
  end

  assign mismatch = (digit_i != cur_digit);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    pos_d    = pos_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    fail_d   = 1'b0;

    case (state_q)
      S_ENTRY: begin
        if (press) begin
          if (pos_q == LAST_POS) begin
            pos_d = '0;
            bad_d = 1'b0;
            if (bad_q | mismatch) begin
              fail_d  = 1'b1;
              tries_d = tries_q - TW'(1);
              if (tries_q == TW'(1)) begin
                state_d = S_LOCKOUT;
                cnt_d   = LOCK_LOAD;
              end
            end else begin
              state_d = S_OPEN;
              tries_d = FULL_TRIES;
            end
          end else begin
            pos_d = pos_q + PW'(1);
            bad_d = bad_q | mismatch;
          end
        end
      end

      S_OPEN: begin
        // The press that enters programming is a command, not a digit.
        if (lock_i) begin
          state_d = S_ENTRY;
          pos_d   = '0;
        end else if (press && program_i) begin
          state_d = S_PROG;
          pos_d   = '0;
        end
      end

      S_PROG: begin
        if (lock_i) begin
          state_d = S_OPEN;
          pos_d   = '0;
        end else if (press) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (pos_q == PW'(i)) begin
              shadow_d[i] = digit_i;
            end
          end
          if (pos_q == LAST_POS) begin
            code_d  = shadow_d;
            state_d = S_ENTRY;
            pos_d   = '0;
            tries_d = FULL_TRIES;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end

      S_LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = S_ENTRY;
          pos_d   = '0;
          tries_d = FULL_TRIES;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_ENTRY;
        pos_d   = '0;
      end
    endcase

    unlocked_d   = (state_d == S_OPEN) || (state_d == S_PROG);
    locked_out_d = (state_d == S_LOCKOUT);
  end

  // enter_q resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_ENTRY;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= DEFAULT_CODE;
      pos_q        <= '0;
      tries_q      <= FULL_TRIES;
      cnt_q        <= '0;
      bad_q        <= 1'b0;
      fail_q       <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      enter_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shadow_q     <= shadow_d;
      pos_q        <= pos_d;
      tries_q      <= tries_d;
      cnt_q        <= cnt_d;
      bad_q        <= bad_d;
      fail_q       <= fail_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
      enter_q      <= enter_i;
    end
  end

  assign unlocked_o   = unlocked_q;
  assign fail_o       = fail_q;
  assign locked_out_o = locked_out_q;
  assign pos_o        = pos_q;
  assign tries_left_o = tries_q;

endmodule
